loader_host_responder: RTL and testbench

LOADER_HOST_RESPONDER -- requirements
Module: loader_host_responder

---
 rtl/loader_host_responder.sv | 189 ++++++++++++++++++
 tb/tb_loader_host_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/loader_host_responder.sv
// Host-side responder for a bitstream loader: host fills a word memory, starts a load,
// then the loader pulls words back with fixed-latency single-outstanding reads.
module loader_host_responder #(
  parameter int INTERFACE_WIDTH      = 32,
  parameter int INTERFACE_ADDR_WIDTH = 32,
  parameter int MEM_DEPTH_LOG2       = 10,
  parameter int READ_LATENCY         = 2,
  parameter int START_HOLD           = 2
) (
  input  logic                            iClk,
  input  logic                            iReset,
  input  logic                            iHostWriteEnable,
  input  logic [MEM_DEPTH_LOG2-1:0]       iHostWriteAddress,
  input  logic [INTERFACE_WIDTH-1:0]      iHostWriteData,
  input  logic                            iHostStart,
  input  logic [INTERFACE_ADDR_WIDTH-1:0] iHostOffset,
  output logic                            oHostBusy,
  output logic                            oHostDone,
  output logic                            oError,
  output logic                            oLoaderWriteReq,
  output logic [INTERFACE_WIDTH-1:0]      oLoaderWriteData,
  input  logic                            iLoaderReadReq,
  input  logic [INTERFACE_ADDR_WIDTH-1:0] iLoaderReadAddress,
  output logic [INTERFACE_WIDTH-1:0]      oLoaderReadData,
  output logic                            oLoaderReadDataValid,
  input  logic                            iConfigDone
);

  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_RELEASE, ST_SERVE} state_t;

  state_t                       r_state;
  logic [3:0]                   r_hold_cnt;
  logic                         r_wr_req;
  logic [INTERFACE_WIDTH-1:0]   r_wr_data;
  logic                         r_busy;
  logic                         r_done;
  logic                         r_err;
  logic                         r_cfg_prev;

  logic [INTERFACE_WIDTH-1:0]   r_mem [DEPTH];
  logic [INTERFACE_WIDTH-1:0]   r_rd_word;
  logic [INTERFACE_WIDTH-1:0]   r_rd_out;
  logic                         r_rd_pend;
  logic [3:0]                   r_rd_cnt;
  logic                         r_rd_valid;

  logic [MEM_DEPTH_LOG2-1:0]    w_rd_idx;
  logic                         w_rd_hi;
  logic                         w_rd_bad;
  logic                         w_rd_accept;
  logic                         w_rd_drop;
  logic                         w_wr_drop;
  logic                         w_cfg_rise;
  logic                         w_err_set;

  assign w_rd_idx = iLoaderReadAddress[MEM_DEPTH_LOG2+1:2];

  // Byte addresses beyond the memory only exist when the address bus is wider.
  generate
    if (INTERFACE_ADDR_WIDTH > MEM_DEPTH_LOG2 + 2) begin : g_hi
      assign w_rd_hi = |iLoaderReadAddress[INTERFACE_ADDR_WIDTH-1:MEM_DEPTH_LOG2+2];
    end else begin : g_no_hi
      assign w_rd_hi = 1'b0;
    end
  endgenerate

  assign w_rd_bad    = (iLoaderReadAddress[1:0] != 2'b00) || w_rd_hi;
  assign w_rd_accept = iLoaderReadReq && !r_rd_pend;
  assign w_rd_drop   = iLoaderReadReq && r_rd_pend;
  assign w_wr_drop   = iHostWriteEnable && (r_state != ST_IDLE);
  assign w_cfg_rise  = iConfigDone && !r_cfg_prev;
  assign w_err_set   = w_wr_drop || w_rd_drop ||
                       (w_rd_accept && (w_rd_bad || (r_state != ST_SERVE)));

  always_ff @(posedge iClk) begin
    if (iHostWriteEnable && (r_state == ST_IDLE)) begin
      r_mem[iHostWriteAddress] <= iHostWriteData;
    end
  end

  // Word is captured at acceptance so later host writes cannot alter a pending response.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_rd_word <= '0;
    end else if (w_rd_accept) begin
      r_rd_word <= w_rd_bad ? '0 : r_mem[w_rd_idx];
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_rd_pend  <= 1'b0;
      r_rd_cnt   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_out   <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      if (READ_LATENCY == 1) begin
        if (w_rd_accept) begin
          r_rd_valid <= 1'b1;
        end
      end else begin
        if (r_rd_pend) begin
          if (r_rd_cnt == 4'd0) begin
            r_rd_pend  <= 1'b0;
            r_rd_valid <= 1'b1;
            r_rd_out   <= r_rd_word;
          end else begin
            r_rd_cnt <= r_rd_cnt - 4'd1;
          end
        end
        if (w_rd_accept) begin
          r_rd_pend <= 1'b1;
          r_rd_cnt  <= 4'(READ_LATENCY - 2);
        end
      end
    end
  end

  // With single-cycle latency the capture register already changes only on valid cycles.
  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign oLoaderReadData = r_rd_word;
    end else begin : g_latn
      assign oLoaderReadData = r_rd_out;
    end
  endgenerate

  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      r_wr_req   <= 1'b0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_cfg_prev <= 1'b0;
    end else begin
      r_cfg_prev <= iConfigDone;
      r_done     <= 1'b0;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (iHostStart) begin
            r_state    <= ST_START;
            r_hold_cnt <= 4'(START_HOLD - 1);
            r_wr_req   <= 1'b1;
            r_wr_data  <= INTERFACE_WIDTH'(iHostOffset);
            r_busy     <= 1'b1;
            r_err      <= w_err_set;
          end
        end
        ST_START: begin
          if (r_hold_cnt == 4'd0) begin
            r_state  <= ST_RELEASE;
            r_wr_req <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt - 4'd1;
          end
        end
        ST_RELEASE: begin
          r_state   <= ST_SERVE;
          r_wr_data <= '0;
        end
        ST_SERVE: begin
          if (w_cfg_rise) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign oHostBusy            = r_busy;
  assign oHostDone            = r_done;
  assign oError               = r_err;
  assign oLoaderWriteReq      = r_wr_req;
  assign oLoaderWriteData     = r_wr_data;
  assign oLoaderReadDataValid = r_rd_valid;

endmodule

// File: tb/tb_loader_host_responder.sv
// Directed bench for loader_host_responder with default parameters
// (32-bit data/address, 1024 words, read latency 2, start hold 2).
module tb_loader_host_responder;

  logic        iClk = 1'b0;
  logic        iReset;
  logic        iHostWriteEnable;
  logic [9:0]  iHostWriteAddress;
  logic [31:0] iHostWriteData;
  logic        iHostStart;
  logic [31:0] iHostOffset;
  logic        oHostBusy;
  logic        oHostDone;
  logic        oError;
  logic        oLoaderWriteReq;
  logic [31:0] oLoaderWriteData;
  logic        iLoaderReadReq;
  logic [31:0] iLoaderReadAddress;
  logic [31:0] oLoaderReadData;
  logic        oLoaderReadDataValid;
  logic        iConfigDone;

  int n_compared   = 0;
  int n_mismatched = 0;

  loader_host_responder dut (
    .iClk                 (iClk),
    .iReset               (iReset),
    .iHostWriteEnable     (iHostWriteEnable),
    .iHostWriteAddress    (iHostWriteAddress),
    .iHostWriteData       (iHostWriteData),
    .iHostStart           (iHostStart),
    .iHostOffset          (iHostOffset),
    .oHostBusy            (oHostBusy),
    .oHostDone            (oHostDone),
    .oError               (oError),
    .oLoaderWriteReq      (oLoaderWriteReq),
    .oLoaderWriteData     (oLoaderWriteData),
    .iLoaderReadReq       (iLoaderReadReq),
    .iLoaderReadAddress   (iLoaderReadAddress),
    .oLoaderReadData      (oLoaderReadData),
    .oLoaderReadDataValid (oLoaderReadDataValid),
    .iConfigDone          (iConfigDone)
  );

  always #5 iClk = ~iClk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("  ok %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic host_write(input logic [9:0] a, input logic [31:0] d);
    iHostWriteEnable  = 1'b1;
    iHostWriteAddress = a;
    iHostWriteData    = d;
    tick();
    iHostWriteEnable  = 1'b0;
  endtask

  // Starts a load and walks START(2) and RELEASE(1) into SERVE.
  task automatic start_to_serve(input logic [31:0] off);
    iHostStart  = 1'b1;
    iHostOffset = off;
    tick();
    iHostStart  = 1'b0;
    check_eq("busy_after_start", {31'd0, oHostBusy}, 32'd1);
    check_eq("err_cleared_on_start", {31'd0, oError}, 32'd0);
    tick();
    tick();
    tick();
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    iLoaderReadReq     = 1'b1;
    iLoaderReadAddress = a;
    tick();
    iLoaderReadReq     = 1'b0;
    check_eq({tag, "_valid_early"}, {31'd0, oLoaderReadDataValid}, 32'd0);
    tick();
    check_eq({tag, "_valid"}, {31'd0, oLoaderReadDataValid}, 32'd1);
    check_eq({tag, "_data"}, oLoaderReadData, exp);
    tick();
    check_eq({tag, "_valid_off"}, {31'd0, oLoaderReadDataValid}, 32'd0);
    check_eq({tag, "_data_held"}, oLoaderReadData, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, {31'd0, oHostBusy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, oHostDone}, 32'd0);
    check_eq({tag, "_err"}, {31'd0, oError}, 32'd0);
    check_eq({tag, "_wreq"}, {31'd0, oLoaderWriteReq}, 32'd0);
    check_eq({tag, "_wdata"}, oLoaderWriteData, 32'd0);
    check_eq({tag, "_rvalid"}, {31'd0, oLoaderReadDataValid}, 32'd0);
    check_eq({tag, "_rdata"}, oLoaderReadData, 32'd0);
  endtask

  initial begin
    iReset = 1'b1; iHostWriteEnable = 1'b0; iHostWriteAddress = '0; iHostWriteData = '0;
    iHostStart = 1'b0; iHostOffset = '0; iLoaderReadReq = 1'b0; iLoaderReadAddress = '0;
    iConfigDone = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    iReset = 1'b0;

    host_write(10'd0, 32'h0000_0005);
    host_write(10'd1, 32'hA5A5_A5A5);
    host_write(10'd2, 32'h1234_5678);
    check_eq("idle_write_no_err", {31'd0, oError}, 32'd0);

    // Load 1: config-done already high before SERVE must not complete the load.
    iConfigDone = 1'b1;
    iHostStart  = 1'b1;
    iHostOffset = 32'h40;
    tick();
    iHostStart  = 1'b0;
    check_eq("s1_busy", {31'd0, oHostBusy}, 32'd1);
    check_eq("s1_wreq", {31'd0, oLoaderWriteReq}, 32'd1);
    check_eq("s1_wdata", oLoaderWriteData, 32'h40);
    tick();
    check_eq("s2_wreq", {31'd0, oLoaderWriteReq}, 32'd1);
    check_eq("s2_wdata", oLoaderWriteData, 32'h40);
    tick();
    check_eq("rel_wreq", {31'd0, oLoaderWriteReq}, 32'd0);
    check_eq("rel_wdata", oLoaderWriteData, 32'h40);
    tick();
    check_eq("serve_wdata", oLoaderWriteData, 32'd0);
    check_eq("serve_busy", {31'd0, oHostBusy}, 32'd1);
    check_eq("serve_no_done", {31'd0, oHostDone}, 32'd0);

    do_read("rd0", 32'h0, 32'h0000_0005);
    do_read("rd4", 32'h4, 32'hA5A5_A5A5);

    // Request on the valid cycle is accepted.
    iLoaderReadReq = 1'b1; iLoaderReadAddress = 32'h8;
    tick();
    iLoaderReadReq = 1'b0;
    tick();
    check_eq("b2b_v1", {31'd0, oLoaderReadDataValid}, 32'd1);
    check_eq("b2b_d1", oLoaderReadData, 32'h1234_5678);
    iLoaderReadReq = 1'b1; iLoaderReadAddress = 32'h0;
    tick();
    iLoaderReadReq = 1'b0;
    check_eq("b2b_gap", {31'd0, oLoaderReadDataValid}, 32'd0);
    tick();
    check_eq("b2b_v2", {31'd0, oLoaderReadDataValid}, 32'd1);
    check_eq("b2b_d2", oLoaderReadData, 32'h0000_0005);
    check_eq("b2b_no_err", {31'd0, oError}, 32'd0);

    iHostStart = 1'b1; iHostOffset = 32'h99;
    tick();
    iHostStart = 1'b0;
    check_eq("start_in_serve_wreq", {31'd0, oLoaderWriteReq}, 32'd0);
    check_eq("start_in_serve_err", {31'd0, oError}, 32'd0);
    check_eq("still_busy", {31'd0, oHostBusy}, 32'd1);

    iConfigDone = 1'b0;
    tick();
    check_eq("cfg_low_no_done", {31'd0, oHostDone}, 32'd0);
    iConfigDone = 1'b1;
    tick();
    check_eq("done_pulse", {31'd0, oHostDone}, 32'd1);
    check_eq("done_busy", {31'd0, oHostBusy}, 32'd0);
    tick();
    check_eq("done_one_cycle", {31'd0, oHostDone}, 32'd0);

    // Read in IDLE is served but flags an error.
    do_read("idle_rd", 32'h4, 32'hA5A5_A5A5);
    check_eq("idle_rd_err", {31'd0, oError}, 32'd1);

    start_to_serve(32'h0);
    iLoaderReadReq = 1'b1; iLoaderReadAddress = 32'h0;
    tick();
    iLoaderReadAddress = 32'h4;
    tick();
    iLoaderReadReq = 1'b0;
    check_eq("dup_v", {31'd0, oLoaderReadDataValid}, 32'd1);
    check_eq("dup_d", oLoaderReadData, 32'h0000_0005);
    check_eq("dup_err", {31'd0, oError}, 32'd1);
    tick();
    check_eq("dup_gap1", {31'd0, oLoaderReadDataValid}, 32'd0);
    tick();
    check_eq("dup_gap2", {31'd0, oLoaderReadDataValid}, 32'd0);

    do_read("misalign", 32'h6, 32'h0);
    do_read("rd4b", 32'h4, 32'hA5A5_A5A5);
    do_read("range", 32'h1000, 32'h0);
    check_eq("bad_err", {31'd0, oError}, 32'd1);

    host_write(10'd0, 32'hDEAD_BEEF);
    do_read("wr_dropped", 32'h0, 32'h0000_0005);

    iConfigDone = 1'b0;
    tick();
    iConfigDone = 1'b1;
    tick();
    check_eq("done2", {31'd0, oHostDone}, 32'd1);
    check_eq("err_sticky", {31'd0, oError}, 32'd1);

    // Host write during read latency must not alter the pending response.
    iLoaderReadReq = 1'b1; iLoaderReadAddress = 32'h0;
    tick();
    iLoaderReadReq = 1'b0;
    iHostWriteEnable = 1'b1; iHostWriteAddress = 10'd0; iHostWriteData = 32'h77;
    tick();
    iHostWriteEnable = 1'b0;
    check_eq("lat_wr_v", {31'd0, oLoaderReadDataValid}, 32'd1);
    check_eq("lat_wr_d", oLoaderReadData, 32'h0000_0005);
    tick();
    do_read("new_word", 32'h0, 32'h77);

    // Reset one cycle after a read request aborts the load and the response.
    start_to_serve(32'h10);
    iLoaderReadReq = 1'b1; iLoaderReadAddress = 32'h4;
    tick();
    iLoaderReadReq = 1'b0;
    iReset = 1'b1;
    tick();
    check_all_zero("midrst");
    iReset = 1'b0;
    tick();
    check_eq("midrst_no_valid", {31'd0, oLoaderReadDataValid}, 32'd0);
    check_eq("midrst_no_done", {31'd0, oHostDone}, 32'd0);
    start_to_serve(32'h0);
    do_read("after_rst", 32'h4, 32'hA5A5_A5A5);
    do_read("after_rst0", 32'h0, 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
